// File: rtl/stp_converter.sv
// stp_converter: serial byte stream to 4-byte column converter with a ready/valid
// handshake on both sides and column indexing within a 16-byte AES block.
module stp_converter (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] d0,
   output logic [7:0] d1,
   output logic [7:0] d2,
   output logic [7:0] d3,
   output logic       col_valid,
   input  logic       out_ready,
   output logic [1:0] col_idx,
   output logic       block_last
);
   logic [1:0] byte_cnt;
   logic [1:0] col_cnt;
   logic [7:0] a0, a1, a2;
   logic       acc;
   logic       load;
   // only the closing byte must wait for the output register to drain
   assign in_ready   = en & ~((byte_cnt == 2'd3) & col_valid & ~out_ready);
   assign acc        = in_valid & in_ready;
   assign load       = acc & (byte_cnt == 2'd3);
   assign block_last = col_valid & (col_idx == 2'd3);
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt  <= 2'd0;
         col_cnt   <= 2'd0;
         a0        <= 8'd0;
         a1        <= 8'd0;
         a2        <= 8'd0;
         d0        <= 8'd0;
         d1        <= 8'd0;
         d2        <= 8'd0;
         d3        <= 8'd0;
         col_idx   <= 2'd0;
         col_valid <= 1'b0;
      end else begin
         if (acc) byte_cnt <= byte_cnt + 2'd1;
         if (acc && byte_cnt == 2'd0) a0 <= data_in;
         if (acc && byte_cnt == 2'd1) a1 <= data_in;
         if (acc && byte_cnt == 2'd2) a2 <= data_in;
         if (load) begin
            d0      <= a0;
            d1      <= a1;
            d2      <= a2;
            d3      <= data_in;
            col_idx <= col_cnt;
            col_cnt <= col_cnt + 2'd1;
         end
         col_valid <= load | (col_valid & ~out_ready);
      end
   end
endmodule

// File: tb/tb_stp_converter.sv
// tb_stp_converter: directed stimulus checked against a byte-list/column model
// every cycle, plus literal expectations for the scenarios of interest.
module tb_stp_converter;
   logic       clk = 1'b0;
   logic       rst, en, in_valid, out_ready;
   logic [7:0] data_in;
   logic       in_ready, col_valid, block_last;
   logic [7:0] d0, d1, d2, d3;
   logic [1:0] col_idx;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       chk_on = 1'b0;
   int         m_n;
   logic [7:0] m_asm [4];
   logic [7:0] m_col [4];
   logic       m_hv;
   int         m_colnum;
   int         m_hidx;

   stp_converter dut (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .col_valid(col_valid), .out_ready(out_ready), .col_idx(col_idx),
      .block_last(block_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic exp_ready();
      return en && !(m_n == 3 && m_hv && !out_ready);
   endfunction

   // model: accepted bytes collect in a list; every fourth one closes a column
   always @(posedge clk) begin
      logic ok;
      if (rst) begin
         m_n = 0;
         m_hv = 1'b0;
         m_colnum = 0;
         m_hidx = 0;
      end else begin
         ok = in_valid && exp_ready();
         if (m_hv && out_ready) m_hv = 1'b0;
         if (ok) begin
            m_asm[m_n] = data_in;
            m_n++;
            if (m_n == 4) begin
               m_col = m_asm;
               m_hv = 1'b1;
               m_hidx = m_colnum % 4;
               m_colnum++;
               m_n = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
         check("col_valid", {31'd0, col_valid}, {31'd0, m_hv});
         if (m_hv) begin
            check("d0", {24'd0, d0}, {24'd0, m_col[0]});
            check("d1", {24'd0, d1}, {24'd0, m_col[1]});
            check("d2", {24'd0, d2}, {24'd0, m_col[2]});
            check("d3", {24'd0, d3}, {24'd0, m_col[3]});
            check("col_idx", {30'd0, col_idx}, m_hidx);
            check("block_last", {31'd0, block_last}, {31'd0, m_hidx == 3});
         end
      end
   end

   task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] d, input logic o);
      rst = r;
      en = e;
      in_valid = v;
      data_in = d;
      out_ready = o;
      @(posedge clk);
      #2;
   endtask

   task automatic lit_col(input string nm, input logic [31:0] b0, input logic [31:0] b3, input logic [31:0] idx);
      check({nm, "_valid"}, {31'd0, col_valid}, 1);
      check({nm, "_d0"}, {24'd0, d0}, b0);
      check({nm, "_d3"}, {24'd0, d3}, b3);
      check({nm, "_idx"}, {30'd0, col_idx}, idx);
   endtask

   initial begin
      drive(1, 1, 0, 8'h00, 1);
      chk_on = 1'b1;
      drive(1, 1, 0, 8'h00, 1);
      check("rst_valid", {31'd0, col_valid}, 0);
      check("rst_d0", {24'd0, d0}, 0);
      check("rst_idx", {30'd0, col_idx}, 0);
      check("rst_last", {31'd0, block_last}, 0);
      check("rst_ready", {31'd0, in_ready}, 1);
      for (int i = 0; i < 16; i++) drive(0, 1, 1, 8'(i), 1);
      lit_col("blk3", 32'h0C, 32'h0F, 3);
      check("blk3_last", {31'd0, block_last}, 1);
      drive(0, 1, 1, 8'h01, 1);
      drive(0, 1, 1, 8'h11, 1);
      drive(0, 1, 1, 8'h22, 1);
      drive(0, 1, 1, 8'h33, 0);
      lit_col("basic", 32'h01, 32'h33, 0);
      check("basic_d1", {24'd0, d1}, 32'h11);
      check("basic_last", {31'd0, block_last}, 0);
      drive(0, 1, 1, 8'h44, 0);
      drive(0, 1, 1, 8'h55, 0);
      drive(0, 1, 1, 8'h66, 0);
      data_in = 8'h77;
      #1;
      check("bp_ready", {31'd0, in_ready}, 0);
      drive(0, 1, 1, 8'h77, 0);
      drive(0, 1, 1, 8'h77, 0);
      lit_col("bp_hold", 32'h01, 32'h33, 0);
      drive(0, 1, 1, 8'h77, 1);
      lit_col("simul", 32'h44, 32'h77, 1);
      check("simul_d2", {24'd0, d2}, 32'h66);
      drive(0, 1, 0, 8'h00, 1);
      check("drain_valid", {31'd0, col_valid}, 0);
      drive(0, 1, 1, 8'h88, 1);
      drive(0, 1, 1, 8'h99, 1);
      drive(0, 0, 1, 8'hAA, 1);
      check("en_ready", {31'd0, in_ready}, 0);
      drive(0, 0, 1, 8'hAA, 1);
      drive(0, 1, 1, 8'hAA, 0);
      drive(0, 1, 1, 8'hBB, 0);
      lit_col("en", 32'h88, 32'hBB, 2);
      check("en_d2", {24'd0, d2}, 32'hAA);
      drive(0, 0, 0, 8'h00, 0);
      check("enlow_hold", {31'd0, col_valid}, 1);
      drive(0, 0, 0, 8'h00, 1);
      check("enlow_xfer", {31'd0, col_valid}, 0);
      drive(0, 1, 1, 8'h12, 1);
      drive(0, 1, 1, 8'h34, 1);
      drive(1, 1, 1, 8'h56, 1);
      check("mrst_valid", {31'd0, col_valid}, 0);
      check("mrst_d0", {24'd0, d0}, 0);
      check("mrst_d3", {24'd0, d3}, 0);
      check("mrst_ready", {31'd0, in_ready}, 1);
      rst = 1'b0;
      en = 1'b0;
      #1;
      check("mrst_ready_en0", {31'd0, in_ready}, 0);
      drive(0, 1, 1, 8'hCC, 0);
      drive(0, 1, 1, 8'hDD, 0);
      drive(0, 1, 1, 8'hEE, 0);
      drive(0, 1, 1, 8'hFF, 0);
      lit_col("after_rst", 32'hCC, 32'hFF, 0);
      drive(0, 1, 0, 8'h00, 1);
      drive(0, 1, 0, 8'h00, 1);
      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
